studio2_keypad: RTL and testbench

Keypad responder for the Studio II core. Converts MiSTer `ps2_key` events into a 20-key pressed-state map: keypad 1 on the main-row digits, keypad 2 on the numeric keypad. It answers the CDP1802 keypad scan: the CPU writes a key-select nibble with OUT 2, and the block drives EF3 (keypad 1) and EF4 (keypad 2) low while the selected key is held. It sits between the PS/2 input and the CPU EF/IO pins, replacing ad-hoc EF muxing in the top level.

---
 rtl/studio2_keypad.sv | 166 ++++++++++++++++
 tb/tb_studio2_keypad.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/studio2_keypad.sv
// studio2_keypad: PS/2 key events -> Studio II dual 10-key pressed maps, answering the CDP1802 EF3/EF4 scan.
// Optional tap stretching so short presses survive the frame-rate scan: define STUDIO2_KEY_HOLD_EN.

module studio2_keypad_pad #(
  parameter logic [23:0] HOLD_CYCLES = 24'd400000
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic [9:0] hit,
  input  logic       press,
  input  logic [3:0] key_sel,
  output logic [9:0] state,
  output logic       ef_n
);
  logic [9:0] state_nxt;

`ifdef STUDIO2_KEY_HOLD_EN
  logic [23:0] cnt, cnt_nxt;
  logic [9:0]  pend, pend_nxt;
  logic        expire;

  assign expire = (cnt >= HOLD_CYCLES);

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    cnt_nxt   = expire ? cnt : cnt + 24'd1;
    if (expire) begin
      state_nxt = state & ~pend;
      pend_nxt  = '0;
    end
    if (|hit) begin
      if (press) begin
        state_nxt = state_nxt | hit;
        pend_nxt  = pend_nxt & ~hit;
        cnt_nxt   = '0;
      end else if (expire) begin
        state_nxt = state_nxt & ~hit;
      end else begin
        // Early release: keep the key visible until the hold window closes.
        pend_nxt = pend_nxt | hit;
      end
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      cnt  <= '0;
      pend <= '0;
    end else begin
      cnt  <= cnt_nxt;
      pend <= pend_nxt;
    end
  end
`else
  logic unused_hold;
  assign unused_hold = ^HOLD_CYCLES;

  always_comb begin
    state_nxt = state;
    if (|hit) state_nxt = press ? (state | hit) : (state & ~hit);
  end
`endif

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state <= '0;
      ef_n  <= 1'b1;
    end else begin
      state <= state_nxt;
      ef_n  <= (key_sel <= 4'd9) ? ~state[key_sel] : 1'b1;
    end
  end
endmodule

module studio2_keypad #(
  parameter logic [23:0] HOLD_CYCLES = 24'd400000
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic [10:0] ps2_key,
  input  logic [2:0]  io_n,
  input  logic        io_out,
  input  logic [7:0]  io_dout,
  output logic        ef3_n,
  output logic        ef4_n,
  output logic [3:0]  key_sel,
  output logic [9:0]  kp1_state,
  output logic [9:0]  kp2_state
);
  localparam int NUM_PADS = 2;

  typedef struct packed {
    logic       tog;
    logic       pressed;
    logic       ext;
    logic [7:0] code;
  } ps2_evt_t;

  ps2_evt_t                 evt;
  logic                     old_tog;
  logic                     event_v;
  logic [NUM_PADS-1:0][9:0] hit;
  logic [NUM_PADS-1:0][9:0] state;
  logic [NUM_PADS-1:0]      ef_n;

  assign evt     = ps2_key;
  assign event_v = (evt.tog != old_tog) && !evt.ext;

  // Pad 0 = main-row digits, pad 1 = numeric keypad.
  always_comb begin
    hit = '0;
    if (event_v) begin
      case (evt.code)
        8'h45: hit[0][0] = 1'b1;
        8'h16: hit[0][1] = 1'b1;
        8'h1E: hit[0][2] = 1'b1;
        8'h26: hit[0][3] = 1'b1;
        8'h25: hit[0][4] = 1'b1;
        8'h2E: hit[0][5] = 1'b1;
        8'h36: hit[0][6] = 1'b1;
        8'h3D: hit[0][7] = 1'b1;
        8'h3E: hit[0][8] = 1'b1;
        8'h46: hit[0][9] = 1'b1;
        8'h70: hit[1][0] = 1'b1;
        8'h69: hit[1][1] = 1'b1;
        8'h72: hit[1][2] = 1'b1;
        8'h7A: hit[1][3] = 1'b1;
        8'h6B: hit[1][4] = 1'b1;
        8'h73: hit[1][5] = 1'b1;
        8'h74: hit[1][6] = 1'b1;
        8'h6C: hit[1][7] = 1'b1;
        8'h75: hit[1][8] = 1'b1;
        8'h7D: hit[1][9] = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      old_tog <= 1'b0;
      key_sel <= '0;
    end else begin
      old_tog <= evt.tog;
      if (io_out && io_n == 3'd2) key_sel <= io_dout[3:0];
    end
  end

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    studio2_keypad_pad #(.HOLD_CYCLES(HOLD_CYCLES)) u_pad (
      .clk     (clk),
      .resetq  (resetq),
      .hit     (hit[p]),
      .press   (evt.pressed),
      .key_sel (key_sel),
      .state   (state[p]),
      .ef_n    (ef_n[p])
    );
  end

  assign kp1_state = state[0];
  assign kp2_state = state[1];
  assign ef3_n     = ef_n[0];
  assign ef4_n     = ef_n[1];
endmodule

// File: tb/tb_studio2_keypad.sv
// Directed bench for studio2_keypad: key maps, select latch, EF timing, async reset, optional hold window.
module tb_studio2_keypad;
  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic [10:0] ps2_key = '0;
  logic [2:0]  io_n = '0;
  logic        io_out = 1'b0;
  logic [7:0]  io_dout = '0;
  logic        ef3_n, ef4_n;
  logic [3:0]  key_sel;
  logic [9:0]  kp1_state, kp2_state;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] k1 [10];
  logic [7:0] k2 [10];

  always #5 clk = ~clk;

  studio2_keypad #(.HOLD_CYCLES(24'd100)) dut (
    .clk       (clk),
    .resetq    (resetq),
    .ps2_key   (ps2_key),
    .io_n      (io_n),
    .io_out    (io_out),
    .io_dout   (io_dout),
    .ef3_n     (ef3_n),
    .ef4_n     (ef4_n),
    .key_sel   (key_sel),
    .kp1_state (kp1_state),
    .kp2_state (kp2_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic key(input logic pr, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pr, ext, code};
    tick();
  endtask

  task automatic sel(input logic [7:0] d);
    io_out = 1'b1; io_n = 3'd2; io_dout = d;
    tick();
    io_out = 1'b0; io_n = 3'd0;
  endtask

  task automatic do_reset();
    resetq = 1'b0;
    ps2_key = '0;
    tick();
    resetq = 1'b1;
    tick();
  endtask

  initial begin
    k1 = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    k2 = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
    tick();
    chk("rst_kp1", kp1_state, 0);
    chk("rst_kp2", kp2_state, 0);
    chk("rst_sel", key_sel, 0);
    chk("rst_ef3", ef3_n, 1);
    chk("rst_ef4", ef4_n, 1);
    resetq = 1'b1;
    tick();

    // Press "1" on pad 1 and OUT 2 with 01 in the same cycle.
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h16};
    io_out = 1'b1; io_n = 3'd2; io_dout = 8'h01;
    tick();
    io_out = 1'b0; io_n = 3'd0;
    chk("p1_kp1", kp1_state, 10'h002);
    chk("p1_sel", key_sel, 1);
    chk("p1_ef3_early", ef3_n, 1);
    tick();
    chk("p1_ef3", ef3_n, 0);
    chk("p1_ef4", ef4_n, 1);

    // Only OUT 2 loads the select latch.
    io_out = 1'b1; io_n = 3'd3; io_dout = 8'h05;
    tick();
    io_out = 1'b0; io_n = 3'd2;
    tick();
    io_n = 3'd0;
    chk("sel_not_out2", key_sel, 1);

`ifdef STUDIO2_KEY_HOLD_EN
    do_reset();
    key(1'b1, 1'b0, 8'h26);
    tick(9);
    key(1'b0, 1'b0, 8'h26);
    chk("hold_after_rel", kp1_state[3], 1);
    tick(70);
    chk("hold_e81", kp1_state[3], 1);
    tick(30);
    chk("hold_e111", kp1_state[3], 0);
    key(1'b1, 1'b0, 8'h26);
    tick(9);
    key(1'b0, 1'b0, 8'h26);
    tick(39);
    key(1'b1, 1'b0, 8'h26);
    tick(60);
    chk("hold_repress", kp1_state[3], 1);
`else
    do_reset();
    sel(8'h09);
    key(1'b1, 1'b0, 8'h7D);
    chk("np9_kp2", kp2_state, 10'h200);
    tick();
    chk("np9_ef4_lo", ef4_n, 0);
    chk("np9_ef3", ef3_n, 1);
    key(1'b0, 1'b0, 8'h7D);
    chk("np9_rel_kp2", kp2_state, 0);
    chk("np9_rel_ef4_lag", ef4_n, 0);
    tick();
    chk("np9_rel_ef4", ef4_n, 1);
`endif

    // Key maps: every pad-1 key, even pad-2 keys, then scan all selects.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      key(1'b1, 1'b0, k1[i]);
      chk($sformatf("map1_%0d", i), kp1_state, (32'h1 << (i + 1)) - 1);
    end
    for (int i = 0; i < 10; i += 2) begin
      key(1'b1, 1'b0, k2[i]);
      chk($sformatf("map2_%0d", i), kp2_state[i], 1);
    end
    chk("map2_all", kp2_state, 10'h155);
    for (int d = 0; d < 16; d++) begin
      sel(8'(d));
      tick();
      chk($sformatf("scan_ef3_%0d", d), ef3_n, (d <= 9) ? 0 : 1);
      chk($sformatf("scan_ef4_%0d", d), ef4_n, (d <= 9 && d % 2 == 0) ? 0 : 1);
    end

    // Keys 0 and 9 on both pads; select 0xA then 0.
    do_reset();
    key(1'b1, 1'b0, 8'h45);
    key(1'b1, 1'b0, 8'h46);
    key(1'b1, 1'b0, 8'h70);
    key(1'b1, 1'b0, 8'h7D);
    sel(8'h0A);
    chk("selA_sel", key_sel, 4'hA);
    tick();
    chk("selA_ef3", ef3_n, 1);
    chk("selA_ef4", ef4_n, 1);
    sel(8'hF0);
    tick();
    chk("sel0_ef3", ef3_n, 0);
    chk("sel0_ef4", ef4_n, 0);

    // Extended and unmapped events leave state alone; no repeat without a toggle.
    key(1'b0, 1'b1, 8'h70);
    chk("ext_kp2", kp2_state, 10'h201);
    key(1'b1, 1'b1, 8'h69);
    chk("ext_press_kp2", kp2_state, 10'h201);
    key(1'b1, 1'b0, 8'h1C);
    chk("unmap_kp1", kp1_state, 10'h201);
    key(1'b1, 1'b0, 8'h3D);
    tick(100);
    chk("notog_kp1", kp1_state, 10'h281);
    chk("notog_kp2", kp2_state, 10'h201);

    // Async reset between clock edges.
    sel(8'h05);
    key(1'b1, 1'b0, 8'h2E);
    tick();
    chk("pre_rst_ef3", ef3_n, 0);
    #2 resetq = 1'b0;
    #1;
    chk("arst_kp1", kp1_state, 0);
    chk("arst_kp2", kp2_state, 0);
    chk("arst_sel", key_sel, 0);
    chk("arst_ef3", ef3_n, 1);
    chk("arst_ef4", ef4_n, 1);
    @(negedge clk);
    ps2_key = '0;
    resetq = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
